// File: rtl/ex_muldiv_seq_pkg.sv
// rtl/ex_muldiv_seq_pkg.sv - shared encodings, states and constants for the RV32M sequencer
package ex_muldiv_seq_pkg;

  localparam logic [2:0] MD_MUL    = 3'd0;
  localparam logic [2:0] MD_MULH   = 3'd1;
  localparam logic [2:0] MD_MULHSU = 3'd2;
  localparam logic [2:0] MD_MULHU  = 3'd3;
  localparam logic [2:0] MD_DIV    = 3'd4;
  localparam logic [2:0] MD_DIVU   = 3'd5;
  localparam logic [2:0] MD_REM    = 3'd6;
  localparam logic [2:0] MD_REMU   = 3'd7;

  localparam logic [31:0] MD_ALL_ONES = 32'hFFFF_FFFF;
  localparam logic [31:0] MD_INT_MIN  = 32'h8000_0000;

  typedef enum logic [2:0] {IDLE, PREP, CALC, FIX, DONE} mdState_t;

  function automatic logic [31:0] condNeg(input logic [31:0] v, input logic neg);
    return neg ? (~v + 32'd1) : v;
  endfunction

endpackage

// File: rtl/ex_muldiv_seq_iter.sv
// rtl/ex_muldiv_seq_iter.sv - muldiv_iter_core: shift-add multiply / restoring divide, one step per enable
module muldiv_iter_core (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        load,
  input  logic        step,
  input  logic        isDiv,
  input  logic [31:0] opA,
  input  logic [31:0] opB,
  output logic [63:0] acc
);

  logic [31:0] operandB;
  logic [32:0] mulSum;
  logic [32:0] divPart;
  logic [32:0] divDiff;
  logic [63:0] accNext;

  // acc = {hi, lo}: product accumulates in hi as the multiplier shifts out of lo;
  // for divide, hi is the partial remainder and lo collects quotient bits.
  always_comb begin
    mulSum  = {1'b0, acc[63:32]} + {1'b0, operandB};
    divPart = acc[63:31];
    divDiff = divPart - {1'b0, operandB};
    accNext = acc;
    if (isDiv) begin
      if (!divDiff[32]) accNext = {divDiff[31:0], acc[30:0], 1'b1};
      else              accNext = {divPart[31:0], acc[30:0], 1'b0};
    end else begin
      if (acc[0]) accNext = {mulSum, acc[31:1]};
      else        accNext = {1'b0, acc[63:1]};
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      acc      <= '0;
      operandB <= '0;
    end else if (load) begin
      acc      <= {32'd0, opA};
      operandB <= opB;
    end else if (step) begin
      acc <= accNext;
    end
  end

endmodule

// File: rtl/ex_muldiv_seq.sv
// rtl/ex_muldiv_seq.sv - RV32M multi-cycle sequencer; MULDIV_EARLY_OUT_EN lets trivial ops skip CALC
module ex_muldiv_seq
  import ex_muldiv_seq_pkg::*;
#(
  parameter int XLEN = 32,
  parameter int ITER = 32
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            StartE,
  input  logic [2:0]      MOpE,
  input  logic [XLEN-1:0] Op1E,
  input  logic [XLEN-1:0] Op2E,
  input  logic [4:0]      RdE,
  input  logic            FlushE,
  output logic            StallMD,
  output logic            BusyMD,
  output logic            DoneMD,
  output logic [XLEN-1:0] ResultMD,
  output logic [4:0]      RdMD
);

  mdState_t    state, nextState;
  logic [2:0]  opReg;
  logic [31:0] aReg, bReg;
  logic [4:0]  rdReg;
  logic [4:0]  cnt;
  logic        negRes;
  logic [63:0] acc;

  logic        neg1, neg2, isDivOp, signNext;
  logic        divByZero, divOverflow, mulZero, earlyOut;
  logic [63:0] mulFull;
  logic [31:0] quot, remd, fixResult;

  always_comb begin
    isDivOp     = opReg[2];
    neg1        = (opReg inside {MD_MULH, MD_MULHSU, MD_DIV, MD_REM}) && aReg[31];
    neg2        = (opReg inside {MD_MULH, MD_DIV, MD_REM}) && bReg[31];
    signNext    = (opReg == MD_REM) ? neg1 : (neg1 ^ neg2);
    divByZero   = isDivOp && (bReg == 32'd0);
    divOverflow = ((opReg == MD_DIV) || (opReg == MD_REM)) &&
                  (aReg == MD_INT_MIN) && (bReg == MD_ALL_ONES);
    mulZero     = !isDivOp && ((aReg == 32'd0) || (bReg == 32'd0));
`ifdef MULDIV_EARLY_OUT_EN
    earlyOut    = divByZero || divOverflow || mulZero;
`else
    earlyOut    = 1'b0;
`endif
  end

  muldiv_iter_core u_core (
    .clk     (clk),
    .reset_n (reset_n),
    .load    (state == PREP),
    .step    (state == CALC),
    .isDiv   (isDivOp),
    .opA     (condNeg(aReg, neg1)),
    .opB     (condNeg(bReg, neg2)),
    .acc     (acc)
  );

  // The full 64-bit product is negated before picking a word so MULH* borrows correctly.
  always_comb begin
    mulFull = negRes ? (~acc + 64'd1) : acc;
    quot    = condNeg(acc[31:0], negRes);
    remd    = condNeg(acc[63:32], negRes);
    unique case (opReg)
      MD_MUL:                      fixResult = mulFull[31:0];
      MD_MULH, MD_MULHSU, MD_MULHU: fixResult = mulFull[63:32];
      MD_DIV, MD_DIVU:             fixResult = quot;
      default:                     fixResult = remd;
    endcase
    if (mulZero)     fixResult = 32'd0;
    if (divByZero)   fixResult = opReg[1] ? aReg : MD_ALL_ONES;
    if (divOverflow) fixResult = opReg[1] ? 32'd0 : MD_INT_MIN;
  end

  always_ff @(posedge clk) begin
    if (!reset_n) state <= IDLE;
    else          state <= nextState;
  end

  always_comb begin
    nextState = state;
    StallMD   = 1'b0;
    BusyMD    = (state != IDLE);
    DoneMD    = (state == DONE) && !FlushE;
    unique case (state)
      IDLE: if (StartE && !FlushE) begin
        nextState = PREP;
        StallMD   = 1'b1;
      end
      PREP: begin
        StallMD   = 1'b1;
        nextState = earlyOut ? FIX : CALC;
      end
      CALC: begin
        StallMD = 1'b1;
        if (cnt == 5'(ITER - 1)) nextState = FIX;
      end
      FIX: begin
        StallMD   = 1'b1;
        nextState = DONE;
      end
      DONE:    nextState = IDLE;
      default: nextState = IDLE;
    endcase
    if (FlushE && (state != IDLE)) nextState = IDLE;
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      opReg    <= '0;
      aReg     <= '0;
      bReg     <= '0;
      rdReg    <= '0;
      cnt      <= '0;
      negRes   <= 1'b0;
      ResultMD <= '0;
      RdMD     <= '0;
    end else begin
      if ((state == IDLE) && StartE && !FlushE) begin
        opReg <= MOpE;
        aReg  <= Op1E;
        bReg  <= Op2E;
        rdReg <= RdE;
      end
      if (state == PREP) negRes <= signNext;
      // Counter wraps 31 -> 0 exactly on the CALC -> FIX edge.
      if (FlushE || (state == PREP)) cnt <= '0;
      else if (state == CALC)        cnt <= cnt + 5'd1;
      if ((state == FIX) && !FlushE) begin
        ResultMD <= fixResult;
        RdMD     <= rdReg;
      end
    end
  end

endmodule

// File: tb/tb_ex_muldiv_seq.sv
// tb/tb_ex_muldiv_seq.sv - self-checking bench for ex_muldiv_seq against an arithmetic reference model
module tb_ex_muldiv_seq;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        StartE = 1'b0;
  logic [2:0]  MOpE = '0;
  logic [31:0] Op1E = '0, Op2E = '0;
  logic [4:0]  RdE = '0;
  logic        FlushE = 1'b0;
  logic        StallMD, BusyMD, DoneMD;
  logic [31:0] ResultMD;
  logic [4:0]  RdMD;

  int nCmp = 0, nBad = 0, cyc = 0;
  int mS = -100, mL = 35, mKill = 1 << 30;
  logic [31:0] mRes = '0, holdRes = '0;
  logic [4:0]  mRd = '0, holdRd = '0;
  bit chkEn = 1'b0;

  ex_muldiv_seq dut (
    .clk(clk), .reset_n(reset_n), .StartE(StartE), .MOpE(MOpE), .Op1E(Op1E), .Op2E(Op2E),
    .RdE(RdE), .FlushE(FlushE), .StallMD(StallMD), .BusyMD(BusyMD), .DoneMD(DoneMD),
    .ResultMD(ResultMD), .RdMD(RdMD)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    nCmp++;
    if (act !== exp) begin
      nBad++;
      $display("FAIL %s cyc=%0d: got %h want %h", name, cyc, act, exp);
    end
  endtask

  function automatic logic [31:0] refResult(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    logic signed [63:0] sa, sb;
    logic [63:0] ua, ub, p;
    int ia, ib;
    sa = {{32{a[31]}}, a};
    sb = {{32{b[31]}}, b};
    ua = {32'd0, a};
    ub = {32'd0, b};
    ia = int'(a);
    ib = int'(b);
    p  = '0;
    case (op)
      3'd0: begin p = ua * ub; return p[31:0]; end
      3'd1: begin p = sa * sb; return p[63:32]; end
      3'd2: begin p = sa * $signed(ub); return p[63:32]; end
      3'd3: begin p = ua * ub; return p[63:32]; end
      3'd4: begin
        if (b == 0) return 32'hFFFF_FFFF;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h8000_0000;
        return 32'(ia / ib);
      end
      3'd5: return (b == 0) ? 32'hFFFF_FFFF : a / b;
      3'd6: begin
        if (b == 0) return a;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'd0;
        return 32'(ia % ib);
      end
      default: return (b == 0) ? a : a % b;
    endcase
  endfunction

  function automatic int latencyOf(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
`ifdef MULDIV_EARLY_OUT_EN
    if (op >= 3'd4 && b == 0) return 3;
    if ((op == 3'd4 || op == 3'd6) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 3;
    if (op < 3'd4 && (a == 0 || b == 0)) return 3;
`endif
    return 35;
  endfunction

  // Per-cycle comparison against the cycle-window model of the current op.
  always @(negedge clk) begin
    bit eS, eB, eD;
    if (chkEn) begin
      eS = (cyc >= mS) && (cyc < mS + mL) && (cyc <= mKill);
      eB = (cyc > mS) && (cyc <= mS + mL) && (cyc <= mKill);
      eD = (cyc == mS + mL) && (cyc <= mKill);
      if (eD) begin
        holdRes = mRes;
        holdRd  = mRd;
      end
      check("StallMD", 32'(StallMD), 32'(eS));
      check("BusyMD", 32'(BusyMD), 32'(eB));
      check("DoneMD", 32'(DoneMD), 32'(eD));
      check("ResultMD", ResultMD, holdRes);
      check("RdMD", 32'(RdMD), 32'(holdRd));
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic scramble();
    MOpE = 3'($urandom);
    Op1E = $urandom;
    Op2E = $urandom;
    RdE  = 5'($urandom);
  endtask

  task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b, input logic [4:0] rd);
    StartE = 1'b1;
    MOpE = op; Op1E = a; Op2E = b; RdE = rd;
    mS = cyc; mL = latencyOf(op, a, b); mKill = 1 << 30;
    mRes = refResult(op, a, b); mRd = rd;
  endtask

  task automatic runOp(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b, input logic [4:0] rd,
                       input int hold, input bit useLit, input logic [31:0] lit, output int stallCnt);
    int lat;
    issue(op, a, b, rd);
    lat = mL;
    stallCnt = 0;
    #1 if (StallMD) stallCnt++;
    for (int i = 0; i < lat; i++) begin
      tick();
      if (i >= hold) StartE = 1'b0;
      scramble();
      #1 if (StallMD) stallCnt++;
    end
    check("DoneMD_at_latency", 32'(DoneMD), 32'd1);
    if (useLit) begin
      check("literal_result", ResultMD, lit);
      check("literal_rd", 32'(RdMD), 32'(rd));
    end
    tick();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout want finish");
    nBad++;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nBad);
    $fatal(1, "watchdog");
  end

  initial begin
    int sc;
    logic [31:0] specials [5];
    logic [2:0]  op;
    logic [31:0] a, b;
    specials[0] = 32'd0; specials[1] = 32'd1; specials[2] = 32'hFFFF_FFFF;
    specials[3] = 32'h8000_0000; specials[4] = 32'h7FFF_FFFF;

    repeat (3) tick();
    check("reset_StallMD", 32'(StallMD), 32'd0);
    check("reset_BusyMD", 32'(BusyMD), 32'd0);
    check("reset_DoneMD", 32'(DoneMD), 32'd0);
    check("reset_ResultMD", ResultMD, 32'd0);
    check("reset_RdMD", 32'(RdMD), 32'd0);
    chkEn = 1'b1;
    reset_n = 1'b1;
    tick();

    runOp(3'd0, 32'd7, 32'hFFFF_FFFD, 5'd9, 0, 1'b1, 32'hFFFF_FFEB, sc);
    check("MUL_stall_cycles", 32'(sc), 32'd35);
    runOp(3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd1, 0, 1'b1, 32'hFFFF_FFFE, sc);
    runOp(3'd1, 32'h8000_0000, 32'h8000_0000, 5'd2, 0, 1'b1, 32'h4000_0000, sc);
    runOp(3'd2, 32'hFFFF_FFFF, 32'd2, 5'd3, 0, 1'b1, 32'hFFFF_FFFF, sc);
    runOp(3'd4, 32'hFFFF_FFEC, 32'd3, 5'd4, 0, 1'b1, 32'hFFFF_FFFA, sc);
    runOp(3'd6, 32'hFFFF_FFEC, 32'd3, 5'd5, 0, 1'b1, 32'hFFFF_FFFE, sc);
    runOp(3'd5, 32'd100, 32'd7, 5'd6, 0, 1'b1, 32'd14, sc);
    runOp(3'd7, 32'd100, 32'd7, 5'd7, 0, 1'b1, 32'd2, sc);
    runOp(3'd5, 32'd5, 32'd0, 5'd8, 0, 1'b1, 32'hFFFF_FFFF, sc);
    runOp(3'd6, 32'd5, 32'd0, 5'd10, 0, 1'b1, 32'd5, sc);
    runOp(3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 5'd11, 0, 1'b1, 32'h8000_0000, sc);
    runOp(3'd5, 32'd1000, 32'd7, 5'd12, 30, 1'b1, 32'd142, sc);

    // Flush at CALC iteration 10, then DIVU 9/2 two cycles later.
    issue(3'd3, $urandom | 32'd1, $urandom | 32'd1, 5'd13);
    tick();
    StartE = 1'b0;
    repeat (11) tick();
    FlushE = 1'b1;
    mKill = cyc;
    tick();
    FlushE = 1'b0;
    #1;
    check("flush_StallMD", 32'(StallMD), 32'd0);
    check("flush_BusyMD", 32'(BusyMD), 32'd0);
    tick();
    runOp(3'd5, 32'd9, 32'd2, 5'd17, 0, 1'b1, 32'd4, sc);

    // Reset asserted at CALC iteration 20.
    issue(3'd4, 32'hFFFF_FC18, 32'd7, 5'd21);
    tick();
    StartE = 1'b0;
    repeat (21) tick();
    reset_n = 1'b0;
    mKill = cyc;
    tick();
    holdRes = '0;
    holdRd  = '0;
    check("midreset_StallMD", 32'(StallMD), 32'd0);
    check("midreset_BusyMD", 32'(BusyMD), 32'd0);
    check("midreset_DoneMD", 32'(DoneMD), 32'd0);
    check("midreset_ResultMD", ResultMD, 32'd0);
    check("midreset_RdMD", 32'(RdMD), 32'd0);
    reset_n = 1'b1;
    tick();

    for (int i = 0; i < 60; i++) begin
      op = 3'($urandom);
      a  = ($urandom_range(0, 3) == 0) ? specials[$urandom_range(0, 4)] : $urandom;
      b  = ($urandom_range(0, 3) == 0) ? specials[$urandom_range(0, 4)] : $urandom;
      if ($urandom_range(0, 3) == 0) b = 32'($urandom_range(0, 15));
      runOp(op, a, b, 5'($urandom), 0, 1'b0, 32'd0, sc);
      repeat ($urandom_range(0, 2)) tick();
    end

    repeat (3) tick();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nBad);
    $finish;
  end

endmodule
